hsv_thresh_sched: RTL and testbench
===================================

// Module: hsv_thresh_sched
// PURPOSE
//  Frame-synchronous threshold scheduler for the HSV colour-mask stage.
//  - Holds NPROF threshold profiles (H/S/V lo/hi each) written by the host.
//  - Drives the active thresholds to the mask comparator; they change only at frame start.
//  - Optionally rotates profiles every DWELL frames.
//  - Counts mask hits per frame and reports the total.
// PARAMETERS
//  NPROF    4   number of profiles (power of 2, >=2)
//  PIDX_W   2   log2(NPROF)
//  DWELL    8   frames per profile in auto mode (>=1)
//  CNT_W    20  width of per-frame hit counter (saturating)
// PORTS
//  clk         in   1        pixel clock; the only clock
//  sys_rst     in   1        asynchronous, active-high reset
//  vs_in       in   1        vertical sync, active-high level; rising edge = frame start
//  de_in       in   1        active-video qualifier
//  mask_in     in   1        comparator hit for current pixel (already aligned with de_in)
//  cfg_we      in   1        profile write strobe (one cycle)
//  cfg_addr    in   PIDX_W   profile index to write
//  cfg_wdata   in   48       {h_lo,h_hi,s_lo,s_hi,v_lo,v_hi}, 8b each, MSB first
//  auto_en     in   1        1 = rotate profiles, 0 = use man_idx
//  man_idx     in   PIDX_W   manual profile select
//  h_lo,h_hi,s_lo,s_hi,v_lo,v_hi  out 8 each  active thresholds (registered)
//  act_idx     out  PIDX_W   index of profile currently driven
//  hit_cnt     out  CNT_W    hits in last completed frame
//  hit_vld     out  1        one-cycle pulse when hit_cnt updates
// BEHAVIOUR
//  Reset: profile table = 0, all threshold outputs 0, act_idx 0, hit_cnt 0, hit_vld 0,
//   dwell counter 0, FSM = S_WAIT, vs_in edge-detect register 0.
//  Frame edge fs = vs_in & ~vs_q (vs_q registered vs_in). One-cycle pulse.
//  FSM: S_WAIT -> S_RUN on first fs (discards the partial frame counted since reset).
//   S_RUN stays S_RUN; sys_rst is the only way back to S_WAIT.
//  Hit counter: in S_RUN, +1 on de_in & mask_in; saturates at all-ones.
//   On fs in S_RUN: hit_cnt <= counter (including a hit in the fs cycle itself); hit_vld = 1 next cycle;
//   counter <= 0.
//   No hit_vld is produced for the S_WAIT->S_RUN fs.
//  Profile selection, evaluated only on fs (both WAIT and RUN):
//   auto_en=0: next = man_idx; dwell counter <= 0.
//   auto_en=1: if dwell == DWELL-1: next = act_idx+1 (wraps NPROF-1 -> 0), dwell <= 0;
//    else next = act_idx, dwell <= dwell+1.
//   act_idx and all six threshold outputs load from table[next] in the cycle after fs.
//   Between fs pulses outputs are frozen; cfg writes and man_idx changes take effect only at next fs.
//  Config write: cfg_we writes table[cfg_addr] on the same clock edge; never blocked.
//   Write and fs in same cycle to the selected profile: the new cfg_wdata is loaded (write-through).
//  No lo<=hi check; the comparator interprets a lo>hi range as its own rule.
//  auto_en toggling mid-frame is sampled only at fs.
//  Reset mid-frame: every register returns to its reset value immediately, the table included.
// STRUCTURE
//  Shared package hsv_pkg: PROF_W=48, field offsets (H_LO_OFS..V_HI_OFS), typedef prof_t
//   (six 8-bit fields); the colour-mask comparator also uses these.
//  One sub-module: hsv_prof_ram (NPROF x 48 register file, 1 write port, 1 async read port).
//  Top: vs edge detect, FSM, dwell counter, hit counter, output registers.
// TESTING
//  1 Reset asserted mid-frame with table loaded -> all outputs 0, table reads 0,
//    next fs only arms (no hit_vld).
//  2 Write p1={10,20,50,200,60,250}, auto_en=0, man_idx=1, then fs -> outputs = p1 one cycle after fs;
//    act_idx=1.
//  3 Auto mode, DWELL=2, NPROF=4, from idx 0 -> sequence per fs 0,1,1,2,2,3,3,0 (wraps).
//  4 Frame with 37 de&mask cycles (5 mask without de) -> hit_cnt=37, hit_vld single pulse
//    after next fs.
//  5 cfg_we to active profile in same cycle as fs -> new data appears on outputs.
//    Mid-frame write -> outputs unchanged until the following fs.
//  6 CNT_W=4, 20 hits in a frame -> hit_cnt=15 (saturated); next frame with 3 hits -> 3.

Source files
------------

// File: rtl/hsv_pkg.sv
// Shared HSV threshold definitions: profile layout used by the scheduler and the mask comparator.
package hsv_pkg;

  localparam int unsigned PROF_W   = 48;
  localparam int unsigned H_LO_OFS = 40;
  localparam int unsigned H_HI_OFS = 32;
  localparam int unsigned S_LO_OFS = 24;
  localparam int unsigned S_HI_OFS = 16;
  localparam int unsigned V_LO_OFS = 8;
  localparam int unsigned V_HI_OFS = 0;

  // Field order matches the packed word, MSB first.
  typedef struct packed {
    logic [7:0] h_lo;
    logic [7:0] h_hi;
    logic [7:0] s_lo;
    logic [7:0] s_hi;
    logic [7:0] v_lo;
    logic [7:0] v_hi;
  } prof_t;

  typedef enum logic {StWait, StRun} sched_state_e;

  function automatic prof_t to_prof(input logic [PROF_W-1:0] word);
    return prof_t'(word);
  endfunction

endpackage

// File: rtl/hsv_prof_ram.sv
// Threshold profile register file: one synchronous write port, one asynchronous read port.
module hsv_prof_ram
  import hsv_pkg::*;
#(
  parameter int unsigned NPROF  = 4,
  parameter int unsigned PIDX_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [PIDX_W-1:0] waddr_i,
  input  logic [PROF_W-1:0] wdata_i,
  input  logic [PIDX_W-1:0] raddr_i,
  output logic [PROF_W-1:0] rdata_o
);

  logic [PROF_W-1:0] mem_q [NPROF];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NPROF; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hsv_thresh_sched.sv
// Frame-synchronous HSV threshold scheduler: swaps profiles only at frame start and
// reports the per-frame mask hit count.
module hsv_thresh_sched
  import hsv_pkg::*;
#(
  parameter int unsigned NPROF  = 4,
  parameter int unsigned PIDX_W = 2,
  parameter int unsigned DWELL  = 8,
  parameter int unsigned CNT_W  = 20
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              vs_in,
  input  logic              de_in,
  input  logic              mask_in,
  input  logic              cfg_we,
  input  logic [PIDX_W-1:0] cfg_addr,
  input  logic [PROF_W-1:0] cfg_wdata,
  input  logic              auto_en,
  input  logic [PIDX_W-1:0] man_idx,
  output logic [7:0]        h_lo,
  output logic [7:0]        h_hi,
  output logic [7:0]        s_lo,
  output logic [7:0]        s_hi,
  output logic [7:0]        v_lo,
  output logic [7:0]        v_hi,
  output logic [PIDX_W-1:0] act_idx,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              hit_vld
);

  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  sched_state_e      state_q, state_d;
  logic              vs_q;
  logic [DW_W-1:0]   dwell_q, dwell_d, dwell_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic              hit_vld_q, hit_vld_d;
  logic [PIDX_W-1:0] act_idx_q, act_idx_d, next_idx;
  prof_t             thr_q, thr_d;
  logic [PROF_W-1:0] rd_data, sel_prof;
  logic              fs, hit;

  assign fs  = vs_in & ~vs_q;
  assign hit = de_in & mask_in;

  hsv_prof_ram #(
    .NPROF  (NPROF),
    .PIDX_W (PIDX_W)
  ) u_prof_ram (
    .clk_i   (clk),
    .rst_i   (sys_rst),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (next_idx),
    .rdata_o (rd_data)
  );

  // A write landing on the profile being selected must be seen this frame.
  assign sel_prof = (cfg_we && (cfg_addr == next_idx)) ? cfg_wdata : rd_data;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    next_idx  = act_idx_q;
    dwell_nxt = '0;
    if (!auto_en) begin
      next_idx = man_idx;
    end else if (dwell_q == DW_W'(DWELL - 1)) begin
      next_idx = act_idx_q + PIDX_W'(1);
    end else begin
      dwell_nxt = dwell_q + DW_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    hit_cnt_d = hit_cnt_q;
    hit_vld_d = 1'b0;
    act_idx_d = act_idx_q;
    thr_d     = thr_q;

    unique case (state_q)
      StWait: begin
        if (fs) state_d = StRun;
      end
      StRun: begin
        if (fs) begin
          hit_cnt_d = hit ? cnt_inc : cnt_q;
          hit_vld_d = 1'b1;
          cnt_d     = '0;
        end else if (hit) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StWait;
    endcase

    if (fs) begin
      dwell_d   = dwell_nxt;
      act_idx_d = next_idx;
      thr_d     = to_prof(sel_prof);
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= StWait;
      vs_q      <= 1'b0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      hit_cnt_q <= '0;
      hit_vld_q <= 1'b0;
      act_idx_q <= '0;
      thr_q     <= '0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vs_in;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      hit_cnt_q <= hit_cnt_d;
      hit_vld_q <= hit_vld_d;
      act_idx_q <= act_idx_d;
      thr_q     <= thr_d;
    end
  end

  assign h_lo    = thr_q.h_lo;
  assign h_hi    = thr_q.h_hi;
  assign s_lo    = thr_q.s_lo;
  assign s_hi    = thr_q.s_hi;
  assign v_lo    = thr_q.v_lo;
  assign v_hi    = thr_q.v_hi;
  assign act_idx = act_idx_q;
  assign hit_cnt = hit_cnt_q;
  assign hit_vld = hit_vld_q;

endmodule

// File: tb/tb_hsv_thresh_sched.sv
// Directed bench for hsv_thresh_sched: threshold scheduling checked inline, hit counts via
// a scoreboard drained on hit_vld. A second instance with a 4-bit counter covers saturation.
module tb_hsv_thresh_sched;
  import hsv_pkg::*;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        vs_in = 1'b0, de_in = 1'b0, mask_in = 1'b0, cfg_we = 1'b0, auto_en = 1'b0;
  logic [1:0]  cfg_addr = '0, man_idx = '0;
  logic [47:0] cfg_wdata = '0;

  logic [7:0]  h_lo, h_hi, s_lo, s_hi, v_lo, v_hi;
  logic [1:0]  act_idx;
  logic [19:0] hit_cnt;
  logic        hit_vld;

  logic [7:0]  sh_lo, sh_hi, ss_lo, ss_hi, sv_lo, sv_hi;
  logic [1:0]  s_act_idx;
  logic [3:0]  s_hit_cnt;
  logic        s_hit_vld;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  logic [3:0]  exp_sat_q[$];
  logic [47:0] model[4];

  always #5 clk = ~clk;

  hsv_thresh_sched #(.NPROF(4), .PIDX_W(2), .DWELL(2), .CNT_W(20)) u_dut (
    .clk(clk), .sys_rst(sys_rst), .vs_in(vs_in), .de_in(de_in), .mask_in(mask_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .auto_en(auto_en),
    .man_idx(man_idx), .h_lo(h_lo), .h_hi(h_hi), .s_lo(s_lo), .s_hi(s_hi), .v_lo(v_lo),
    .v_hi(v_hi), .act_idx(act_idx), .hit_cnt(hit_cnt), .hit_vld(hit_vld)
  );

  hsv_thresh_sched #(.NPROF(4), .PIDX_W(2), .DWELL(2), .CNT_W(4)) u_sat (
    .clk(clk), .sys_rst(sys_rst), .vs_in(vs_in), .de_in(de_in), .mask_in(mask_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .auto_en(auto_en),
    .man_idx(man_idx), .h_lo(sh_lo), .h_hi(sh_hi), .s_lo(ss_lo), .s_hi(ss_hi), .v_lo(sv_lo),
    .v_hi(sv_hi), .act_idx(s_act_idx), .hit_cnt(s_hit_cnt), .hit_vld(s_hit_vld)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [47:0] prof, input logic [1:0] idx);
    check({tag, "_thr"}, 64'({h_lo, h_hi, s_lo, s_hi, v_lo, v_hi}), 64'(prof));
    check({tag, "_idx"}, 64'(act_idx), 64'(idx));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [47:0] data);
    cfg_we = 1'b1; cfg_addr = idx; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
    model[idx] = data;
  endtask

  task automatic frame_start();
    vs_in = 1'b1;
    tick();
    vs_in = 1'b0;
    tick();
  endtask

  task automatic hits(input int n);
    de_in = 1'b1; mask_in = 1'b1;
    repeat (n) tick();
    de_in = 1'b0; mask_in = 1'b0;
  endtask

  task automatic push_exp(input int n);
    exp_q.push_back(20'(n));
    exp_sat_q.push_back(4'((n > 15) ? 15 : n));
  endtask

  always @(negedge clk) begin
    if (hit_vld === 1'b1) begin
      check("hit_vld_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("hit_cnt", 64'(hit_cnt), 64'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (s_hit_vld === 1'b1) begin
      check("sat_hit_vld_pending", 64'(exp_sat_q.size() != 0), 64'(1));
      if (exp_sat_q.size() != 0) check("sat_hit_cnt", 64'(s_hit_cnt), 64'(exp_sat_q.pop_front()));
    end
  end

  initial begin
    logic [47:0] p0, p1, p2, p3, pnew, pnew2;
    int seq[8];
    seq   = '{0, 1, 1, 2, 2, 3, 3, 0};
    p0    = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    p1    = {8'd10, 8'd20, 8'd50, 8'd200, 8'd60, 8'd250};
    p2    = {8'd90, 8'd30, 8'd77, 8'd88, 8'd99, 8'd11};
    p3    = {8'hf0, 8'hf1, 8'hf2, 8'hf3, 8'hf4, 8'hf5};
    pnew  = {8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};
    pnew2 = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc};
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset state
    repeat (3) tick();
    check_outputs("reset", 48'h0, 2'd0);
    check("reset_hit_cnt", 64'(hit_cnt), 64'(0));
    check("reset_hit_vld", 64'(hit_vld), 64'(0));
    sys_rst = 1'b0;
    tick();

    // Arm, load p1, then reset mid-frame
    cfg_write(2'd1, p1);
    man_idx = 2'd1;
    frame_start();
    check_outputs("arm_load", p1, 2'd1);
    hits(6);
    #2 sys_rst = 1'b1;
    #1;
    check_outputs("async_rst", 48'h0, 2'd0);
    check("async_rst_hit_vld", 64'(hit_vld), 64'(0));
    @(posedge clk);
    #1 sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    tick();

    // Hits before the arming edge are discarded; table was cleared
    hits(4);
    frame_start();
    check_outputs("table_cleared", 48'h0, 2'd1);

    // Mid-frame write held until the next frame start
    cfg_write(2'd1, p1);
    check_outputs("midframe_hold", 48'h0, 2'd1);
    push_exp(0);
    frame_start();
    check_outputs("p1_load", p1, 2'd1);

    // 37 qualified hits, plus mask-only and de-only cycles that must not count
    cfg_write(2'd0, p0);
    cfg_write(2'd2, p2);
    cfg_write(2'd3, p3);
    hits(20);
    mask_in = 1'b1; repeat (5) tick(); mask_in = 1'b0;
    de_in = 1'b1; repeat (3) tick(); de_in = 1'b0;
    hits(17);
    push_exp(37);
    man_idx = 2'd0;
    frame_start();
    check_outputs("man0", p0, 2'd0);

    // Saturation frame, then a 3-hit frame whose last hit lands in the fs cycle
    hits(20);
    push_exp(20);
    frame_start();
    hits(2);
    push_exp(3);
    de_in = 1'b1; mask_in = 1'b1; vs_in = 1'b1;
    tick();
    de_in = 1'b0; mask_in = 1'b0; vs_in = 1'b0;
    tick();

    // Auto rotation with DWELL=2
    auto_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_exp(0);
      frame_start();
      check_outputs($sformatf("auto%0d", i), model[seq[i]], 2'(seq[i]));
      check($sformatf("sat_auto%0d_idx", i), 64'(s_act_idx), 64'(seq[i]));
    end

    // Write-through at fs, then a mid-frame write deferred to the next fs
    auto_en = 1'b0;
    man_idx = 2'd2;
    push_exp(0);
    vs_in = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = pnew;
    tick();
    vs_in = 1'b0; cfg_we = 1'b0;
    model[2] = pnew;
    tick();
    check_outputs("write_through", pnew, 2'd2);
    cfg_write(2'd2, pnew2);
    check_outputs("midframe_write_hold", pnew, 2'd2);
    push_exp(0);
    frame_start();
    check_outputs("deferred_write", pnew2, 2'd2);

    repeat (4) tick();
    check("queue_drained", 64'(exp_q.size() + exp_sat_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
